map_scan_engine: RTL and testbench
==================================

# map_scan_engine

Parametrised successor to the single-cell classifier. On request, it sequentially reads every cell of a map RAM and classifies each byte as start, goal, wall or mark. It latches the first start and goal addresses and counts walls and marks. It sits between the map RAM and the bidirectional-search controller, so the controller receives seed positions and map statistics without walking the RAM itself.

## Interface
- DATA_W, 8: cell width in bits; must be ≥4.
- ADDR_W, 8: map address width.
- CELLS, 256: number of cells scanned, addresses 0..CELLS-1; must satisfy 1 ≤ CELLS ≤ 2^ADDR_W.
- CNT_W, ADDR_W+1: counter width; holds CELLS without overflow.

Ports:
- m_clock  in  1  sole clock, rising edge.
- p_reset  in  1  reset, asynchronous, active-low.
- scan_req  in  1  starts a scan; sampled only in IDLE.
- abort  in  1  cancels a scan in progress.
- mem_rd  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata  in  DATA_W  RAM data, valid the cycle after mem_rd.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when results are final.
- start_found / start_pos  out  1 / ADDR_W  first start cell seen, and its address.
- goal_found / goal_pos  out  1 / ADDR_W  first goal cell seen, and its address.
- wall_cnt, mark_cnt  out  CNT_W each  wall and mark cell counts.
- dup_err  out  1  more than one start cell, or more than one goal cell.
- data_out  out  DATA_W  last cell read, registered.

## Operation
- Cell classes, first match in this order:
  - start: value == {1'b0, all ones}.
  - goal: value == 0.
  - wall: MSB == 1.
  - mark: bits [DATA_W-2:DATA_W-3] == 2'b10.
  - otherwise: free, not counted.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ on scan_req. On that same edge, clear the found flags, positions, counters and dup_err.
  - READ: mem_rd=1. mem_addr steps 0,1,…,CELLS-1, one address per cycle. After issuing CELLS-1, go to DRAIN.
  - DRAIN: mem_rd=0; classify the final returned cell; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- Pipeline: the address is delayed one cycle and paired with mem_rdata. Every returned cell is classified, and data_out loads it.
- First start: sets start_found and start_pos. A later start leaves start_pos unchanged and sets dup_err. The same rule applies to goal.
- Counters saturate never: CNT_W is sized so CELLS fits. wall_cnt = 2^ADDR_W is legal.
- Results hold their values until the next accepted scan_req or reset.

## Timing
- Reset, asynchronous: state IDLE. Every output is 0: busy, done, mem_rd, mem_addr, found flags, positions, counts, dup_err, data_out.
- Scan sequence, with scan_req accepted at edge 0:
  - mem_rd=1 in cycles 1..CELLS, with mem_addr=k in cycle k+1.
  - Cell k is classified at edge k+2.
  - busy=1 in cycles 1..CELLS+1.
  - done=1 in cycle CELLS+2, with busy=0 and results final.
- scan_req in READ, DRAIN or DONE: ignored, with no queueing. The earliest restart is the cycle after done.
- abort in READ or DRAIN: the next state is IDLE, with mem_rd=0 and busy=0 from the next cycle. No done pulse is issued.
  - The in-flight read is discarded.
  - Partial results stay visible but are invalid. The controller relies on done only.
- abort in IDLE or DONE: no effect; the done pulse still completes.
- abort and scan_req together in IDLE: scan_req wins and the scan starts.
- CELLS=1: READ lasts one cycle and done appears in cycle 3.
- Reset asserted mid-scan: immediate return to IDLE, with all outputs 0.

## Test plan
- Reset: assert p_reset=0 mid-cycle → every output is 0 asynchronously; after release, the state stays IDLE with no activity.
- Basic scan, CELLS=16; map is 0x01 everywhere except 0x7F@3, 0x00@12, 0x80@5,6,7, 0x41@9; scan_req at edge 0 → mem_addr 0..15 in cycles 1..16; done in cycle 18; start_pos=3, goal_pos=12, wall_cnt=3, mark_cnt=1, dup_err=0; data_out=0x01.
- Duplicates: 0x7F@2 and 0x7F@9, 0x00@4 → start_pos=2, start_found=1, dup_err=1, goal_pos=4.
- Missing goal, no zero cells: goal_found=0, goal_pos=0, dup_err=0; the done pulse still occurs in cycle 18.
- Abort: abort in cycle 5 → mem_rd=0 and busy=0 from cycle 6, no done. A fresh scan_req then yields clean results identical to the basic scan.
- Full map, CELLS=256: all cells 0xFF and scan_req held high throughout → wall_cnt=256 with no wrap, done in cycle 258. A second scan starts the cycle after done because scan_req is still high.

Source files
------------

// File: rtl/map_scan_engine.sv
// Sequentially scans a map RAM, classifies each cell (start/goal/wall/mark) and
// reports first start/goal positions, wall/mark counts and duplicate seeds.
module map_scan_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CELLS  = 256,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              scan_req,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              start_found,
  output logic [ADDR_W-1:0] start_pos,
  output logic              goal_found,
  output logic [ADDR_W-1:0] goal_pos,
  output logic [CNT_W-1:0]  wall_cnt,
  output logic [CNT_W-1:0]  mark_cnt,
  output logic              dup_err,
  output logic [DATA_W-1:0] data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [DATA_W-1:0] START_VAL = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              rd_vld;
  logic [ADDR_W-1:0] addr_d;
  logic              is_start, is_goal, is_wall, is_mark;

  // Priority classification of the returned cell
  always_comb begin
    is_start = 1'b0;
    is_goal  = 1'b0;
    is_wall  = 1'b0;
    is_mark  = 1'b0;
    if (mem_rdata == START_VAL)                          is_start = 1'b1;
    else if (mem_rdata == '0)                            is_goal  = 1'b1;
    else if (mem_rdata[DATA_W-1])                        is_wall  = 1'b1;
    else if (mem_rdata[DATA_W-2:DATA_W-3] == 2'b10)      is_mark  = 1'b1;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state       <= IDLE;
      rd_vld      <= 1'b0;
      addr_d      <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_found <= 1'b0;
      start_pos   <= '0;
      goal_found  <= 1'b0;
      goal_pos    <= '0;
      wall_cnt    <= '0;
      mark_cnt    <= '0;
      dup_err     <= 1'b0;
      data_out    <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= mem_rd;
      addr_d <= mem_addr;

      // Data returned this cycle belongs to the address issued last cycle
      if (rd_vld) begin
        data_out <= mem_rdata;
        if (is_start) begin
          if (start_found) dup_err <= 1'b1;
          else begin
            start_found <= 1'b1;
            start_pos   <= addr_d;
          end
        end
        if (is_goal) begin
          if (goal_found) dup_err <= 1'b1;
          else begin
            goal_found <= 1'b1;
            goal_pos   <= addr_d;
          end
        end
        if (is_wall) wall_cnt <= wall_cnt + CNT_W'(1);
        if (is_mark) mark_cnt <= mark_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (scan_req) begin
            state       <= READ;
            mem_rd      <= 1'b1;
            mem_addr    <= '0;
            busy        <= 1'b1;
            start_found <= 1'b0;
            start_pos   <= '0;
            goal_found  <= 1'b0;
            goal_pos    <= '0;
            wall_cnt    <= '0;
            mark_cnt    <= '0;
            dup_err     <= 1'b0;
          end
        end
        READ: begin
          if (abort) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            rd_vld   <= 1'b0;
          end else if (mem_addr == LAST_ADDR) begin
            state    <= DRAIN;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          busy   <= 1'b0;
          rd_vld <= 1'b0;
          if (abort) state <= IDLE;
          else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_scan_engine.sv
// Randomized self-checking bench for map_scan_engine: three instances
// (16, 256 and 1 cells) checked cycle-by-cycle against a map-level model.
module tb_map_scan_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 9;

  typedef struct {
    bit sf; int sp; bit gf; int gp; int wc; int mc; bit dup; int last;
  } res_t;

  logic m_clock = 1'b0;
  logic p_reset = 1'b1;
  always #5 m_clock = ~m_clock;

  int   sel  = 0;
  logic req  = 1'b0;
  logic abrt = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [DW-1:0] map_s [256];
  logic [DW-1:0] map_f [256];
  logic [DW-1:0] map_o [256];

  logic          s_rd, s_busy, s_done, s_sf, s_gf, s_dup;
  logic [AW-1:0] s_addr, s_sp, s_gp;
  logic [CW-1:0] s_wc, s_mc;
  logic [DW-1:0] s_rdata, s_dout;
  logic          f_rd, f_busy, f_done, f_sf, f_gf, f_dup;
  logic [AW-1:0] f_addr, f_sp, f_gp;
  logic [CW-1:0] f_wc, f_mc;
  logic [DW-1:0] f_rdata, f_dout;
  logic          o_rd, o_busy, o_done, o_sf, o_gf, o_dup;
  logic [AW-1:0] o_addr, o_sp, o_gp;
  logic [CW-1:0] o_wc, o_mc;
  logic [DW-1:0] o_rdata, o_dout;
  logic          x_rd, x_busy, x_done, x_sf, x_gf, x_dup;
  logic [AW-1:0] x_addr, x_sp, x_gp;
  logic [CW-1:0] x_wc, x_mc;
  logic [DW-1:0] x_dout;

  map_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .CELLS(16), .CNT_W(CW)) u_small (
    .m_clock(m_clock), .p_reset(p_reset), .scan_req(req && (sel == 0)), .abort(abrt && (sel == 0)),
    .mem_rd(s_rd), .mem_addr(s_addr), .mem_rdata(s_rdata), .busy(s_busy), .done(s_done),
    .start_found(s_sf), .start_pos(s_sp), .goal_found(s_gf), .goal_pos(s_gp),
    .wall_cnt(s_wc), .mark_cnt(s_mc), .dup_err(s_dup), .data_out(s_dout));

  map_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .CELLS(256), .CNT_W(CW)) u_full (
    .m_clock(m_clock), .p_reset(p_reset), .scan_req(req && (sel == 1)), .abort(abrt && (sel == 1)),
    .mem_rd(f_rd), .mem_addr(f_addr), .mem_rdata(f_rdata), .busy(f_busy), .done(f_done),
    .start_found(f_sf), .start_pos(f_sp), .goal_found(f_gf), .goal_pos(f_gp),
    .wall_cnt(f_wc), .mark_cnt(f_mc), .dup_err(f_dup), .data_out(f_dout));

  map_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .CELLS(1), .CNT_W(CW)) u_one (
    .m_clock(m_clock), .p_reset(p_reset), .scan_req(req && (sel == 2)), .abort(abrt && (sel == 2)),
    .mem_rd(o_rd), .mem_addr(o_addr), .mem_rdata(o_rdata), .busy(o_busy), .done(o_done),
    .start_found(o_sf), .start_pos(o_sp), .goal_found(o_gf), .goal_pos(o_gp),
    .wall_cnt(o_wc), .mark_cnt(o_mc), .dup_err(o_dup), .data_out(o_dout));

  // Synchronous-read RAMs: data valid the cycle after the address
  always @(posedge m_clock) begin
    s_rdata <= map_s[s_addr];
    f_rdata <= map_f[f_addr];
    o_rdata <= map_o[o_addr];
  end

  always_comb begin
    case (sel)
      1:       {x_rd, x_busy, x_done, x_sf, x_gf, x_dup, x_addr, x_sp, x_gp, x_wc, x_mc, x_dout} =
               {f_rd, f_busy, f_done, f_sf, f_gf, f_dup, f_addr, f_sp, f_gp, f_wc, f_mc, f_dout};
      2:       {x_rd, x_busy, x_done, x_sf, x_gf, x_dup, x_addr, x_sp, x_gp, x_wc, x_mc, x_dout} =
               {o_rd, o_busy, o_done, o_sf, o_gf, o_dup, o_addr, o_sp, o_gp, o_wc, o_mc, o_dout};
      default: {x_rd, x_busy, x_done, x_sf, x_gf, x_dup, x_addr, x_sp, x_gp, x_wc, x_mc, x_dout} =
               {s_rd, s_busy, s_done, s_sf, s_gf, s_dup, s_addr, s_sp, s_gp, s_wc, s_mc, s_dout};
    endcase
  end

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, act, exp, $time, sel);
    end
  endtask

  function automatic logic [DW-1:0] cell_at(input int which, input int a);
    case (which)
      1:       return map_f[a];
      2:       return map_o[a];
      default: return map_s[a];
    endcase
  endfunction

  // Whole-map reference: walk the cells in address order applying the class rules
  function automatic res_t model(input int which, input int n);
    res_t r = '{default: 0};
    for (int a = 0; a < n; a++) begin
      logic [DW-1:0] v = cell_at(which, a);
      if (v == 8'h7F) begin
        if (r.sf) r.dup = 1'b1;
        else begin r.sf = 1'b1; r.sp = a; end
      end else if (v == 8'h00) begin
        if (r.gf) r.dup = 1'b1;
        else begin r.gf = 1'b1; r.gp = a; end
      end else if (v >= 8'h80) r.wc++;
      else if (v >= 8'h40 && v < 8'h60) r.mc++;
    end
    r.last = int'(cell_at(which, n - 1));
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_cell();
    case ($urandom_range(5))
      0:       return 8'h7F;
      1:       return 8'h00;
      2:       return 8'h80 | 8'($urandom_range(127));
      3:       return 8'h40 | 8'($urandom_range(31));
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  task automatic check_res(input res_t e);
    check("start_found", x_sf, e.sf);
    check("start_pos", x_sp, e.sp);
    check("goal_found", x_gf, e.gf);
    check("goal_pos", x_gp, e.gp);
    check("wall_cnt", x_wc, e.wc);
    check("mark_cnt", x_mc, e.mc);
    check("dup_err", x_dup, e.dup);
    check("data_out", x_dout, e.last);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, x_busy, 0);
    check({tag, "_done"}, x_done, 0);
    check({tag, "_mem_rd"}, x_rd, 0);
    check({tag, "_mem_addr"}, x_addr, 0);
    check({tag, "_results"}, {x_sf, x_gf, x_dup, x_sp, x_gp, x_wc, x_mc}, 0);
    check({tag, "_data_out"}, x_dout, 0);
  endtask

  // One scan of n cells; abort_at = cycle in which abort is high (0: with scan_req, <0: none)
  task automatic scan(input int n, input int abort_at, input bit hold, input res_t e);
    bit ab  = (abort_at >= 1) && (abort_at <= n + 1);
    int lim = hold ? n + 2 : n + 4;
    bit live;
    @(negedge m_clock);
    req  = 1'b1;
    abrt = (abort_at == 0);
    @(posedge m_clock);
    #1;
    if (!hold) req = 1'b0;
    abrt = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge m_clock);
      abrt = (c == abort_at);
      live = !ab || (c <= abort_at);
      check("mem_rd", x_rd, (c <= n) && live);
      if ((c <= n) && live) check("mem_addr", x_addr, c - 1);
      check("busy", x_busy, (c <= n + 1) && live);
      check("done", x_done, !ab && (c == n + 2));
      if (!ab && (c == n + 2)) check_res(e);
    end
    abrt = 1'b0;
    if (!ab && !hold) check_res(e);
  endtask

  task automatic check_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge m_clock);
      check("idle_busy", x_busy, 0);
      check("idle_mem_rd", x_rd, 0);
      check("idle_done", x_done, 0);
    end
  endtask

  initial begin
    res_t e;
    res_t basic;
    int   ab;

    // Asynchronous reset before any clock edge
    #2 p_reset = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge m_clock);
    p_reset = 1'b1;
    check_idle(3);

    // Basic directed map
    sel = 0;
    for (int a = 0; a < 256; a++) map_s[a] = 8'h01;
    map_s[3] = 8'h7F; map_s[12] = 8'h00; map_s[5] = 8'h80; map_s[6] = 8'h80;
    map_s[7] = 8'h80; map_s[9] = 8'h41;
    basic = model(0, 16);
    scan(16, -1, 1'b0, basic);
    check("basic_start_pos", x_sp, 3);
    check("basic_goal_pos", x_gp, 12);
    check("basic_wall_cnt", x_wc, 3);
    check("basic_mark_cnt", x_mc, 1);

    // Abort mid-read, then a clean rescan
    scan(16, 5, 1'b0, basic);
    check_idle(2);
    scan(16, -1, 1'b0, basic);
    // scan_req wins over abort in IDLE; abort in DONE does not cancel done
    scan(16, 0, 1'b0, basic);
    scan(16, 18, 1'b0, basic);

    // Duplicate starts
    for (int a = 0; a < 16; a++) map_s[a] = 8'h01;
    map_s[2] = 8'h7F; map_s[9] = 8'h7F; map_s[4] = 8'h00;
    scan(16, -1, 1'b0, model(0, 16));
    check("dup_start_pos", x_sp, 2);
    check("dup_dup_err", x_dup, 1);
    check("dup_goal_pos", x_gp, 4);

    // Missing goal
    for (int a = 0; a < 16; a++) map_s[a] = 8'h01;
    map_s[1] = 8'h7F; map_s[8] = 8'hC3;
    scan(16, -1, 1'b0, model(0, 16));
    check("nogoal_goal_found", x_gf, 0);
    check("nogoal_goal_pos", x_gp, 0);

    // Randomized 16-cell maps, occasionally aborted (READ, DRAIN, DONE or IDLE)
    for (int i = 0; i < 10; i++) begin
      for (int a = 0; a < 16; a++) map_s[a] = rnd_cell();
      e = model(0, 16);
      if ($urandom_range(2) == 0) begin
        ab = int'($urandom_range(20, 1));
        scan(16, ab, 1'b0, e);
      end
      scan(16, -1, 1'b0, e);
    end

    // Single-cell map
    sel = 2;
    for (int i = 0; i < 6; i++) begin
      map_o[0] = rnd_cell();
      e = model(2, 1);
      if (i % 3 == 2) scan(1, int'($urandom_range(2, 1)), 1'b0, e);
      scan(1, -1, 1'b0, e);
    end

    // Full 256-cell map of walls with scan_req held high
    sel = 1;
    for (int a = 0; a < 256; a++) map_f[a] = 8'hFF;
    e = model(1, 256);
    scan(256, -1, 1'b1, e);
    check("full_wall_cnt", x_wc, 256);
    @(negedge m_clock);
    @(negedge m_clock);
    check("full_restart_busy", x_busy, 1);
    req = 1'b0;
    for (int k = 0; k < 300 && !x_done; k++) @(negedge m_clock);
    check("full_second_done", x_done, 1);
    check_res(e);
    check_idle(2);

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) map_f[a] = rnd_cell();
      scan(256, -1, 1'b0, model(1, 256));
    end

    // Reset asserted in the middle of a scan
    sel = 0;
    for (int a = 0; a < 16; a++) map_s[a] = rnd_cell();
    map_s[0] = 8'h80;
    @(negedge m_clock);
    req = 1'b1;
    @(posedge m_clock);
    #1 req = 1'b0;
    repeat (7) @(negedge m_clock);
    #3 p_reset = 1'b0;
    #1 check_zero("midreset");
    @(negedge m_clock);
    p_reset = 1'b1;
    check_idle(3);
    scan(16, -1, 1'b0, model(0, 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
